// File: rtl/mem_stage_ld_if.sv
// EX->MEM->WB handshake bundle for the load/store memory stage.
// slave is the stage side, master the pipeline/testbench side.
interface mem_stage_ld_if #(
  parameter int DW      = 32,
  parameter int PC_W    = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_mem_en;
  logic               ex_mem_we;
  logic [2:0]         ex_ld_op;
  logic               ex_rf_we;
  logic [4:0]         ex_rf_waddr;
  logic [DW-1:0]      ex_result;
  logic               ex_hi_we;
  logic               ex_lo_we;
  logic [DW-1:0]      ex_hi;
  logic [DW-1:0]      ex_lo;
  logic               dmem_rvalid;
  logic [DW-1:0]      dmem_rdata;

  logic [PC_W-1:0]    wb_pc;
  logic               wb_rf_we;
  logic [4:0]         wb_rf_waddr;
  logic [DW-1:0]      wb_rf_wdata;
  logic               wb_hi_we;
  logic               wb_lo_we;
  logic [DW-1:0]      wb_hi;
  logic [DW-1:0]      wb_lo;
  logic               fwd_rf_we;
  logic [4:0]         fwd_rf_waddr;
  logic [DW-1:0]      fwd_rf_wdata;
  logic               fwd_data_ok;
  logic               stallreq;
  logic               ld_align_err;
  logic               ld_timeout;

  modport slave (
    input  stall, ex_pc, ex_mem_en, ex_mem_we, ex_ld_op, ex_rf_we, ex_rf_waddr,
           ex_result, ex_hi_we, ex_lo_we, ex_hi, ex_lo, dmem_rvalid, dmem_rdata,
    output wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_hi_we, wb_lo_we, wb_hi, wb_lo,
           fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata, fwd_data_ok, stallreq,
           ld_align_err, ld_timeout
  );

  modport master (
    output stall, ex_pc, ex_mem_en, ex_mem_we, ex_ld_op, ex_rf_we, ex_rf_waddr,
           ex_result, ex_hi_we, ex_lo_we, ex_hi, ex_lo, dmem_rvalid, dmem_rdata,
    input  wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_hi_we, wb_lo_we, wb_hi, wb_lo,
           fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata, fwd_data_ok, stallreq,
           ld_align_err, ld_timeout
  );
endinterface

// File: rtl/mem_stage_ld.sv
// MEM stage: EX/MEM register, variable-latency load wait FSM, load align/extend.
// One register stage; rdata used same cycle as rvalid; stallreq held while a load is outstanding.
module mem_stage_ld #(
  parameter int DW      = 32,
  parameter int PC_W    = 32,
  parameter int STALL_W = 6,
  parameter int STG     = 3,
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mem_stage_ld_if.slave bus
);

  localparam int AW = $clog2(DW / 8);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            mem_en;
    logic            mem_we;
    logic [2:0]      ld_op;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [DW-1:0]   result;
    logic            hi_we;
    logic            lo_we;
    logic [DW-1:0]   hi;
    logic [DW-1:0]   lo;
  } pipe_t;

  pipe_t         pipe_q, pipe_d, ex_pipe;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ld_buf_q, ld_buf_d;
  logic          align_err_q, align_err_d;
  logic          timeout_q, timeout_d;

  logic          capture, bubble, ex_is_load, is_load_q, mis_q, stallreq;
  logic [DW-1:0] raw, shifted, ld_data, rf_wdata;
  logic          unused_stall;

  // LD on a 32-bit datapath behaves as LW, so it only needs word alignment.
  function automatic logic misaligned(input logic [2:0] op, input logic [2:0] a);
    case (op)
      3'd3, 3'd4: misaligned = a[0];
      3'd5, 3'd6: misaligned = |a[1:0];
      3'd7:       misaligned = (DW == 64) ? |a : |a[1:0];
      default:    misaligned = 1'b0;
    endcase
  endfunction

  assign capture      = ~bus.stall[STG];
  assign bubble       = bus.stall[STG] & ~bus.stall[STG+1];
  assign unused_stall = ^bus.stall;
  assign ex_is_load   = bus.ex_mem_en & ~bus.ex_mem_we & (bus.ex_ld_op != 3'd0);

  always_comb begin
    ex_pipe.pc       = bus.ex_pc;
    ex_pipe.mem_en   = bus.ex_mem_en;
    ex_pipe.mem_we   = bus.ex_mem_we;
    ex_pipe.ld_op    = bus.ex_ld_op;
    ex_pipe.rf_we    = bus.ex_rf_we;
    ex_pipe.rf_waddr = bus.ex_rf_waddr;
    ex_pipe.result   = bus.ex_result;
    ex_pipe.hi_we    = bus.ex_hi_we;
    ex_pipe.lo_we    = bus.ex_lo_we;
    ex_pipe.hi       = bus.ex_hi;
    ex_pipe.lo       = bus.ex_lo;
  end

  // A capture or bubble always restarts the FSM; in-stage moves only happen while held.
  always_comb begin
    pipe_d      = pipe_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_buf_d    = ld_buf_q;
    align_err_d = 1'b0;
    timeout_d   = 1'b0;
    if (capture) begin
      pipe_d      = ex_pipe;
      state_d     = ex_is_load ? WAIT : IDLE;
      cnt_d       = '0;
      ld_buf_d    = '0;
      align_err_d = ex_is_load & misaligned(bus.ex_ld_op, bus.ex_result[2:0]);
    end else if (bubble) begin
      pipe_d   = '0;
      state_d  = IDLE;
      cnt_d    = '0;
      ld_buf_d = '0;
    end else if (state_q == WAIT) begin
      if (bus.dmem_rvalid) begin
        state_d  = DONE;
        ld_buf_d = bus.dmem_rdata;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d   = DONE;
        ld_buf_d  = '0;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_buf_q    <= '0;
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_buf_q    <= ld_buf_d;
      align_err_q <= align_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign is_load_q = pipe_q.mem_en & ~pipe_q.mem_we & (pipe_q.ld_op != 3'd0);
  assign mis_q     = is_load_q & misaligned(pipe_q.ld_op, pipe_q.result[2:0]);
  assign stallreq  = (state_q == WAIT) & ~bus.dmem_rvalid;

  always_comb begin
    raw = '0;
    if (state_q == WAIT && bus.dmem_rvalid) raw = bus.dmem_rdata;
    else if (state_q == DONE)               raw = ld_buf_q;
  end

  // Little-endian lanes: shift the addressed byte down to bit 0, then extend.
  assign shifted = raw >> {pipe_q.result[AW-1:0], 3'b000};

  always_comb begin
    ld_data = '0;
    case (pipe_q.ld_op)
      3'd1:    ld_data = DW'($signed(shifted[7:0]));
      3'd2:    ld_data = DW'(shifted[7:0]);
      3'd3:    ld_data = DW'($signed(shifted[15:0]));
      3'd4:    ld_data = DW'(shifted[15:0]);
      3'd5:    ld_data = DW'($signed(shifted[31:0]));
      3'd6:    ld_data = DW'(shifted[31:0]);
      3'd7:    ld_data = shifted;
      default: ld_data = '0;
    endcase
  end

  assign rf_wdata = is_load_q ? ld_data : pipe_q.result;

  assign bus.wb_pc        = pipe_q.pc;
  assign bus.wb_rf_we     = pipe_q.rf_we & ~mis_q & ~stallreq;
  assign bus.wb_rf_waddr  = pipe_q.rf_waddr;
  assign bus.wb_rf_wdata  = rf_wdata;
  assign bus.wb_hi_we     = pipe_q.hi_we;
  assign bus.wb_lo_we     = pipe_q.lo_we;
  assign bus.wb_hi        = pipe_q.hi;
  assign bus.wb_lo        = pipe_q.lo;
  // ID keeps seeing the pending write so it interlocks until data is final.
  assign bus.fwd_rf_we    = pipe_q.rf_we & ~mis_q;
  assign bus.fwd_rf_waddr = pipe_q.rf_waddr;
  assign bus.fwd_rf_wdata = rf_wdata;
  assign bus.fwd_data_ok  = ~stallreq;
  assign bus.stallreq     = stallreq;
  assign bus.ld_align_err = align_err_q;
  assign bus.ld_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_stage_ld.sv
// Bench for mem_stage_ld: a 32-bit (TIMEOUT=4) and a 64-bit instance share one stimulus bus.
// Load vectors come from a table; expected write-back values go through a scoreboard queue.
module tb_mem_stage_ld;

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011000;
  localparam logic [5:0] BUB  = 6'b001000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_ld_if #(.DW(32)) i32 ();
  mem_stage_ld_if #(.DW(64)) i64 ();

  mem_stage_ld #(.DW(32), .TIMEOUT(4))  u32 (.clk(clk), .rst(rst), .bus(i32));
  mem_stage_ld #(.DW(64), .TIMEOUT(15)) u64 (.clk(clk), .rst(rst), .bus(i64));

  logic        sel64;
  logic [5:0]  stall;
  logic [31:0] pc;
  logic        mem_en, mem_we, rf_we, hi_we, lo_we, rvalid;
  logic [2:0]  ld_op;
  logic [4:0]  waddr;
  logic [63:0] result, hi, lo, rdata;

  assign i32.stall       = stall;
  assign i32.ex_pc       = pc;
  assign i32.ex_mem_en   = mem_en & ~sel64;
  assign i32.ex_mem_we   = mem_we;
  assign i32.ex_ld_op    = ld_op;
  assign i32.ex_rf_we    = rf_we;
  assign i32.ex_rf_waddr = waddr;
  assign i32.ex_result   = result[31:0];
  assign i32.ex_hi_we    = hi_we;
  assign i32.ex_lo_we    = lo_we;
  assign i32.ex_hi       = hi[31:0];
  assign i32.ex_lo       = lo[31:0];
  assign i32.dmem_rvalid = rvalid;
  assign i32.dmem_rdata  = rdata[31:0];

  assign i64.stall       = stall;
  assign i64.ex_pc       = pc;
  assign i64.ex_mem_en   = mem_en & sel64;
  assign i64.ex_mem_we   = mem_we;
  assign i64.ex_ld_op    = ld_op;
  assign i64.ex_rf_we    = rf_we;
  assign i64.ex_rf_waddr = waddr;
  assign i64.ex_result   = result;
  assign i64.ex_hi_we    = hi_we;
  assign i64.ex_lo_we    = lo_we;
  assign i64.ex_hi       = hi;
  assign i64.ex_lo       = lo;
  assign i64.dmem_rvalid = rvalid;
  assign i64.dmem_rdata  = rdata;

  logic        o_we, o_fwe, o_stall, o_ok, o_aerr, o_to, o_hiwe;
  logic [31:0] o_pc;
  logic [63:0] o_wdata, o_hi;
  assign o_we    = sel64 ? i64.wb_rf_we     : i32.wb_rf_we;
  assign o_fwe   = sel64 ? i64.fwd_rf_we    : i32.fwd_rf_we;
  assign o_stall = sel64 ? i64.stallreq     : i32.stallreq;
  assign o_ok    = sel64 ? i64.fwd_data_ok  : i32.fwd_data_ok;
  assign o_aerr  = sel64 ? i64.ld_align_err : i32.ld_align_err;
  assign o_to    = sel64 ? i64.ld_timeout   : i32.ld_timeout;
  assign o_hiwe  = sel64 ? i64.wb_hi_we     : i32.wb_hi_we;
  assign o_pc    = sel64 ? i64.wb_pc        : i32.wb_pc;
  assign o_wdata = sel64 ? i64.wb_rf_wdata  : {32'd0, i32.wb_rf_wdata};
  assign o_hi    = sel64 ? i64.wb_hi        : {32'd0, i32.wb_hi};

  typedef struct {
    bit          dw64;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] rdata;
    int          dly;
    bit          we;
    bit          aerr;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    bit          we;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_ex(input bit s64, input logic [2:0] op, input bit men,
                          input bit rwe, input logic [63:0] res);
    sel64  = s64;
    stall  = RUN;
    mem_en = men;
    mem_we = 1'b0;
    ld_op  = op;
    rf_we  = rwe;
    waddr  = 5'd7;
    result = res;
    pc     = pc + 32'd4;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    drive_ex(v.dw64, v.op, 1'b1, 1'b1, v.addr);
    rvalid = 1'b0;
    sbq.push_back('{we: v.we, chk_data: !v.aerr, data: v.exp});
    tick();
    stall = HOLD;
    rdata = v.rdata;
    for (int k = 0; k <= v.dly; k++) begin
      rvalid = (k == v.dly);
      sample();
      if (k == 0) chk("align_err_first", {63'd0, o_aerr}, {63'd0, v.aerr});
      if (k < v.dly) begin
        chk("stallreq_wait", {63'd0, o_stall}, 64'd1);
      end else begin
        chk("stallreq_rvalid", {63'd0, o_stall}, 64'd0);
        chk("fwd_data_ok", {63'd0, o_ok}, 64'd1);
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
          e = sbq.pop_front();
          chk("wb_rf_we", {63'd0, o_we}, {63'd0, e.we});
          chk("fwd_rf_we", {63'd0, o_fwe}, {63'd0, e.we});
          if (e.chk_data) chk("wb_rf_wdata", o_wdata, e.data);
        end
      end
      tick();
    end
    rvalid = 1'b0;
    sample();
    if (!v.aerr) chk("done_buffer_wdata", o_wdata, v.exp);
    chk("no_timeout", {63'd0, o_to}, 64'd0);
    chk("align_err_cleared", {63'd0, o_aerr}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 3'd1, 64'h1003, 64'h80FF1234, 2, 1, 0, 64'hFFFFFF80};
    vecs[1] = '{0, 3'd4, 64'h2002, 64'hBEEF0000, 0, 1, 0, 64'h0000BEEF};
    vecs[2] = '{0, 3'd3, 64'h2001, 64'h12345678, 1, 0, 1, 64'h0};
    vecs[3] = '{1, 3'd7, 64'h8,    64'h0123456789ABCDEF, 1, 1, 0, 64'h0123456789ABCDEF};
    vecs[4] = '{1, 3'd5, 64'h4,    64'h8000000000000000, 0, 1, 0, 64'hFFFFFFFF80000000};
    vecs[5] = '{0, 3'd2, 64'h1,    64'h0000AB00, 1, 1, 0, 64'h000000AB};
    vecs[6] = '{1, 3'd6, 64'h4,    64'h8000000000000000, 1, 1, 0, 64'h0000000080000000};
    vecs[7] = '{1, 3'd1, 64'h7,    64'h8000000000000000, 0, 1, 0, 64'hFFFFFFFFFFFFFF80};
    vecs[8] = '{0, 3'd5, 64'h10,   64'hCAFEF00D, 3, 1, 0, 64'hCAFEF00D};
    vecs[9] = '{1, 3'd3, 64'h6,    64'h8001000000000000, 2, 1, 0, 64'hFFFFFFFFFFFF8001};

    sel64 = 1'b0; stall = RUN; pc = 32'h100; mem_en = 1'b0; mem_we = 1'b0;
    ld_op = 3'd0; rf_we = 1'b0; waddr = 5'd0; result = '0; hi = '0; lo = '0;
    hi_we = 1'b0; lo_we = 1'b0; rvalid = 1'b0; rdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_wdata32", {32'd0, i32.wb_rf_wdata}, 64'd0);
    chk("rst_wdata64", i64.wb_rf_wdata, 64'd0);
    chk("rst_pc32", {32'd0, i32.wb_pc}, 64'd0);
    chk("rst_ok32", {63'd0, i32.fwd_data_ok}, 64'd1);
    chk("rst_ok64", {63'd0, i64.fwd_data_ok}, 64'd1);
    chk("rst_stallreq", {63'd0, i32.stallreq | i64.stallreq}, 64'd0);
    chk("rst_pulses", {62'd0, i32.ld_timeout, i64.ld_align_err}, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Capture in the same cycle rvalid arrives, then rvalid seen in IDLE.
    drive_ex(1'b0, 3'd1, 1'b1, 1'b1, 64'h3);
    rvalid = 1'b0;
    rdata  = 64'h7F000000;
    tick();
    stall = HOLD;
    sample();
    chk("cap_rv_wait", {63'd0, o_stall}, 64'd1);
    tick();
    rvalid = 1'b1;
    drive_ex(1'b0, 3'd0, 1'b0, 1'b1, 64'h55);
    sample();
    chk("cap_rv_old_data", o_wdata, 64'h7F);
    chk("cap_rv_nostall", {63'd0, o_stall}, 64'd0);
    tick();
    stall = HOLD;
    sample();
    chk("cap_rv_new_data", o_wdata, 64'h55);
    chk("cap_rv_idle", {63'd0, o_stall}, 64'd0);
    chk("cap_rv_we", {63'd0, o_we}, 64'd1);
    rvalid = 1'b0;

    // Timeout on the TIMEOUT=4 instance.
    drive_ex(1'b0, 3'd5, 1'b1, 1'b1, 64'h0);
    rdata = 64'hFFFFFFFF;
    tick();
    stall = HOLD;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("to_stallreq", {63'd0, o_stall}, 64'd1);
      chk("to_no_pulse_yet", {63'd0, o_to}, 64'd0);
      tick();
    end
    sample();
    chk("to_stall_drop", {63'd0, o_stall}, 64'd0);
    chk("to_pulse", {63'd0, o_to}, 64'd1);
    chk("to_wdata_zero", o_wdata, 64'd0);
    tick();
    sample();
    chk("to_pulse_once", {63'd0, o_to}, 64'd0);

    // Bubble mid-WAIT clears everything, HI/LO fields included.
    drive_ex(1'b0, 3'd5, 1'b1, 1'b1, 64'h40);
    hi_we = 1'b1;
    hi    = 64'hDEAD;
    tick();
    stall = HOLD;
    hi_we = 1'b0;
    sample();
    chk("bub_pre_stall", {63'd0, o_stall}, 64'd1);
    chk("bub_pre_hi_we", {63'd0, o_hiwe}, 64'd1);
    chk("bub_pre_hi", o_hi, 64'hDEAD);
    chk("bub_pre_pc", {32'd0, o_pc}, {32'd0, pc});
    tick();
    stall = BUB;
    tick();
    stall = HOLD;
    sample();
    chk("bub_pc", {32'd0, o_pc}, 64'd0);
    chk("bub_we", {62'd0, o_we, o_fwe}, 64'd0);
    chk("bub_hi", {o_hi[62:0], o_hiwe}, 64'd0);
    chk("bub_wdata", o_wdata, 64'd0);
    chk("bub_idle", {62'd0, o_stall, o_ok}, 64'd1);
    rvalid = 1'b1;
    rdata  = 64'h12345678;
    tick();
    sample();
    chk("bub_rvalid_ignored", o_wdata, 64'd0);
    rvalid = 1'b0;

    // Asynchronous reset mid-WAIT, checked before the next clock edge.
    drive_ex(1'b0, 3'd5, 1'b1, 1'b1, 64'h80);
    tick();
    stall = HOLD;
    sample();
    chk("arst_pre_stall", {63'd0, o_stall}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stallreq", {63'd0, o_stall}, 64'd0);
    chk("arst_ok", {63'd0, o_ok}, 64'd1);
    chk("arst_pc", {32'd0, o_pc}, 64'd0);
    chk("arst_wdata", o_wdata, 64'd0);
    tick();
    rst = 1'b0;

    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
